bnn_neuron_seq: RTL and testbench

- Sequencer for one binary neuron. It owns one internal instance of the ±1 accumulate ALU (alu_op 0 = add, 1 = subtract; fixed a_lsb = 1).
- Per neuron: latches an input bit-vector, a weight bit-vector and a signed bias. It then steps the ALU once per input bit, accumulating +1 on XNOR match and −1 on mismatch.
- Presents the signed pre-activation sum and its sign-activation bit through a valid/ready handshake.
- Sits between the layer-level scheduler (start/busy) and the activation buffer (out_valid/out_ready).

---
 rtl/bnn_neuron_seq_if.sv | 29 ++
 rtl/bnn_neuron_seq.sv | 120 ++++++++++++
 tb/tb_bnn_neuron_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_neuron_seq_if.sv
// Bundle between the layer scheduler / activation buffer and one binary-neuron sequencer.
// Handshake: start is a level request taken only while idle; a result transfers at any
// rising clk edge where out_valid && out_ready, and the producer holds acc_out/y_bit/sat
// stable from out_valid rising until that edge.
interface bnn_neuron_seq_if #(
  parameter int N_IN  = 16,
  parameter int ACC_W = 12
);
  logic             start;
  logic [N_IN-1:0]  x_vec;
  logic [N_IN-1:0]  w_vec;
  logic [ACC_W-1:0] bias;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             y_bit;
  logic             sat;

  modport master (
    output start, x_vec, w_vec, bias, out_ready,
    input  busy, out_valid, acc_out, y_bit, sat
  );

  modport slave (
    input  start, x_vec, w_vec, bias, out_ready,
    output busy, out_valid, acc_out, y_bit, sat
  );
endinterface

// File: rtl/bnn_neuron_seq.sv
// Binary neuron sequencer: one +/-1 ALU step per input bit (XNOR match adds, mismatch
// subtracts), saturating signed accumulator, result offered through valid/ready.
module bnn_acc_alu #(
  parameter int ACC_W = 12
) (
  input  logic             alu_op,
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] y
);
  assign y = alu_op ? (b - a) : (b + a);
endmodule

module bnn_neuron_seq #(
  parameter int N_IN  = 16,
  parameter int ACC_W = 12,
  parameter int IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bnn_neuron_seq_if.slave       bus,
  output logic [1:0]            state_dbg
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

  state_t           state, state_nxt;
  logic [N_IN-1:0]  x_lat, w_lat;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc, alu_out, acc_step;
  logic             sat_run;
  logic [ACC_W-1:0] acc_r;
  logic             y_r, sat_r;
  logic             alu_op, clamp, last, out_valid_c, busy_c;

  // ALU operand a is the fixed +1 step; the sign of the step comes from alu_op.
  bnn_acc_alu #(.ACC_W(ACC_W)) u_alu (
    .alu_op (alu_op),
    .a      (ACC_W'(1)),
    .b      (acc),
    .y      (alu_out)
  );

  assign alu_op   = x_lat[idx] ^ w_lat[idx];
  assign clamp    = (!alu_op && (acc == ACC_MAX)) || (alu_op && (acc == ACC_MIN));
  assign acc_step = clamp ? acc : alu_out;
  assign last     = (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_DONE;
      S_DONE:  if (out_valid_c && bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c      = (state != S_IDLE);
    out_valid_c = (state == S_DONE);
  end

  // Datapath; the published result registers change only when a run completes,
  // so they stay stable under backpressure and after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lat   <= '0;
      w_lat   <= '0;
      idx     <= '0;
      acc     <= '0;
      sat_run <= 1'b0;
      acc_r   <= '0;
      y_r     <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            x_lat   <= bus.x_vec;
            w_lat   <= bus.w_vec;
            acc     <= bus.bias;
            idx     <= '0;
            sat_run <= 1'b0;
          end
        end
        S_RUN: begin
          acc     <= acc_step;
          sat_run <= sat_run | clamp;
          idx     <= last ? '0 : idx + 1'b1;
          if (last) begin
            acc_r <= acc_step;
            y_r   <= ~acc_step[ACC_W-1];
            sat_r <= sat_run | clamp;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_c;
  assign bus.acc_out   = acc_r;
  assign bus.y_bit     = y_r;
  assign bus.sat       = sat_r;
  assign state_dbg     = state;
endmodule

// File: tb/tb_bnn_neuron_seq.sv
// Bench for bnn_neuron_seq: a 12-bit and a 6-bit accumulator instance, model-driven
// scoreboard popped on every handshake, plus latency/backpressure/reset checks.
module tb_bnn_neuron_seq;
  localparam int N_IN  = 16;
  localparam int EXP_W = 14;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bnn_neuron_seq_if #(.N_IN(16), .ACC_W(12)) if12 ();
  bnn_neuron_seq_if #(.N_IN(16), .ACC_W(6))  if6 ();
  logic [1:0] st12, st6;

  bnn_neuron_seq #(.N_IN(16), .ACC_W(12), .IDX_W(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .bus(if12.slave), .state_dbg(st12)
  );
  bnn_neuron_seq #(.N_IN(16), .ACC_W(6), .IDX_W(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(if6.slave), .state_dbg(st6)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp12_q[$];
  logic [EXP_W-1:0] exp6_q[$];
  logic [EXP_W-1:0] e12, e6;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed as {sat, y_bit, acc[11:0] sign-extended}.
  function automatic logic [EXP_W-1:0] model(input logic [15:0] x, input logic [15:0] w,
                                             input int b, input int accw);
    int mx = (1 << (accw - 1)) - 1;
    int mn = -(1 << (accw - 1));
    int a = b;
    bit s = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (x[i] == w[i]) begin
        if (a == mx) s = 1'b1; else a = a + 1;
      end else begin
        if (a == mn) s = 1'b1; else a = a - 1;
      end
    end
    return {s, (a >= 0), 12'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_neuron(input bit sel, input logic [15:0] x, input logic [15:0] w,
                              input int b);
    if (sel) begin
      if6.x_vec = x; if6.w_vec = w; if6.bias = 6'(b); if6.start = 1'b1;
      exp6_q.push_back(model(x, w, b, 6));
    end else begin
      if12.x_vec = x; if12.w_vec = w; if12.bias = 12'(b); if12.start = 1'b1;
      exp12_q.push_back(model(x, w, b, 12));
    end
    tick();
    if6.start  = 1'b0;
    if12.start = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, output int cnt);
    cnt = 0;
    while (!(sel ? if6.out_valid : if12.out_valid) && cnt < 100) begin
      tick();
      cnt++;
    end
    check("valid_seen", {31'b0, (sel ? if6.out_valid : if12.out_valid)}, 32'd1);
  endtask

  // Scoreboard: sampled mid-cycle, the handshake completes at the following rising edge.
  always @(negedge clk) begin
    if (rst_n && if12.out_valid && if12.out_ready) begin
      if (exp12_q.size() == 0) check("spurious12", {31'b0, if12.out_valid}, 32'd0);
      else begin
        e12 = exp12_q.pop_front();
        check("acc12", {20'b0, if12.acc_out}, {20'b0, e12[11:0]});
        check("y12",   {31'b0, if12.y_bit},   {31'b0, e12[12]});
        check("sat12", {31'b0, if12.sat},     {31'b0, e12[13]});
      end
    end
    if (rst_n && if6.out_valid && if6.out_ready) begin
      if (exp6_q.size() == 0) check("spurious6", {31'b0, if6.out_valid}, 32'd0);
      else begin
        e6 = exp6_q.pop_front();
        check("acc6", {20'b0, {6{if6.acc_out[5]}}, if6.acc_out}, {20'b0, e6[11:0]});
        check("y6",   {31'b0, if6.y_bit}, {31'b0, e6[12]});
        check("sat6", {31'b0, if6.sat},   {31'b0, e6[13]});
      end
    end
  end

  initial begin
    int cnt, gap, b;
    logic [15:0] x, w;
    rst_n = 1'b0;
    if12.start = 0; if12.x_vec = '0; if12.w_vec = '0; if12.bias = '0; if12.out_ready = 0;
    if6.start  = 0; if6.x_vec  = '0; if6.w_vec  = '0; if6.bias  = '0; if6.out_ready  = 0;
    repeat (2) tick();
    check("rst_busy",  {31'b0, if12.busy}, 0);
    check("rst_valid", {31'b0, if12.out_valid}, 0);
    check("rst_acc",   {20'b0, if12.acc_out}, 0);
    check("rst_y",     {31'b0, if12.y_bit}, 0);
    check("rst_sat",   {31'b0, if12.sat}, 0);
    check("rst_state", {30'b0, st12}, 0);
    rst_neg: rst_n = 1'b1;
    tick();

    // 1: all match, bias 0
    if12.out_ready = 1'b1;
    start_neuron(0, 16'hFFFF, 16'hFFFF, 0);
    check("t1_busy_run", {31'b0, if12.busy}, 1);
    wait_valid(0, cnt);
    check("t1_latency", cnt, 16);
    check("t1_acc", {20'b0, if12.acc_out}, 32'd16);
    tick();
    check("t1_busy_after", {31'b0, if12.busy}, 0);
    check("t1_valid_after", {31'b0, if12.out_valid}, 0);

    // 2: zero sum counts as positive; negative bias with all mismatches
    start_neuron(0, 16'h00FF, 16'hFFFF, 0);
    wait_valid(0, cnt);
    check("t2a_acc", {20'b0, if12.acc_out}, 32'd0);
    check("t2a_y",   {31'b0, if12.y_bit}, 1);
    tick();
    start_neuron(0, 16'h0000, 16'hFFFF, -3);
    wait_valid(0, cnt);
    check("t2b_acc", {20'b0, if12.acc_out}, 32'hFED);
    check("t2b_y",   {31'b0, if12.y_bit}, 0);
    tick();

    // 3: saturation in the narrow instance
    if6.out_ready = 1'b1;
    start_neuron(1, 16'hFFFF, 16'hFFFF, 25);
    wait_valid(1, cnt);
    check("t3a_acc", {26'b0, if6.acc_out}, 32'd31);
    check("t3a_sat", {31'b0, if6.sat}, 1);
    tick();
    start_neuron(1, 16'h0000, 16'hFFFF, -25);
    wait_valid(1, cnt);
    check("t3b_acc", {26'b0, if6.acc_out}, 32'h20);
    check("t3b_sat", {31'b0, if6.sat}, 1);
    tick();

    // random traffic with variable backpressure
    for (int k = 0; k < 4; k++) begin
      x = 16'($urandom); w = 16'($urandom); b = int'($urandom_range(40, 0)) - 20;
      if12.out_ready = 1'b0;
      start_neuron(0, x, w, b);
      wait_valid(0, cnt);
      check("rnd_latency", cnt, 16);
      repeat ($urandom_range(3, 0)) tick();
      if12.out_ready = 1'b1;
      tick();
      check("rnd_idle", {31'b0, if12.busy}, 0);
    end

    // 4: backpressure with input churn in RUN and DONE
    if12.out_ready = 1'b0;
    start_neuron(0, 16'h5A3C, 16'hF00F, 7);
    cnt = 0;
    while (!if12.out_valid && cnt < 100) begin
      if12.start = 1'($urandom); if12.x_vec = 16'($urandom); if12.bias = 12'($urandom);
      tick();
      cnt++;
    end
    check("t4_latency", cnt, 16);
    for (int i = 0; i < 5; i++) begin
      if12.start = 1'($urandom); if12.x_vec = 16'($urandom); if12.bias = 12'($urandom);
      tick();
      check("t4_hold_valid", {31'b0, if12.out_valid}, 1);
      check("t4_hold_acc", {20'b0, if12.acc_out}, {20'b0, exp12_q[0][11:0]});
      check("t4_hold_y", {31'b0, if12.y_bit}, {31'b0, exp12_q[0][12]});
    end
    if12.start = 1'b0;
    if12.out_ready = 1'b1;
    tick();
    check("t4_hs_valid", {31'b0, if12.out_valid}, 0);
    tick();
    check("t4_idle_state", {30'b0, st12}, 0);

    // 5: asynchronous reset at idx 7
    start_neuron(0, 16'h1234, 16'h0F0F, 5);
    repeat (7) tick();
    check("t5_running", {30'b0, st12}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_acc",   {20'b0, if12.acc_out}, 0);
    check("t5_rst_y",     {31'b0, if12.y_bit}, 0);
    check("t5_rst_sat",   {31'b0, if12.sat}, 0);
    check("t5_rst_busy",  {31'b0, if12.busy}, 0);
    check("t5_rst_state", {30'b0, st12}, 0);
    exp12_q.delete();
    tick();
    #2 rst_n = 1'b1;
    repeat (3) tick();
    check("t5_no_output", {31'b0, if12.out_valid}, 0);
    start_neuron(0, 16'hAAAA, 16'hAAAA, 1);
    wait_valid(0, cnt);
    check("t5_acc", {20'b0, if12.acc_out}, 32'd17);
    check("t5_sat", {31'b0, if12.sat}, 0);
    tick();

    // 6: start held high across two evaluations
    if12.x_vec = 16'hC3A5; if12.w_vec = 16'h0FF0; if12.bias = 12'(-2);
    exp12_q.push_back(model(16'hC3A5, 16'h0FF0, -2, 12));
    exp12_q.push_back(model(16'hC3A5, 16'h0FF0, -2, 12));
    if12.start = 1'b1;
    tick();
    wait_valid(0, cnt);
    check("t6_latency", cnt, 16);
    tick();
    check("t6_idle_gap", {31'b0, if12.busy}, 0);
    gap = 0;
    tick();
    gap++;
    check("t6_restart", {31'b0, if12.busy}, 1);
    if12.start = 1'b0;
    while (!if12.out_valid && gap < 100) begin
      tick();
      gap++;
    end
    tick();
    gap++;
    check("t6_hs_gap", gap, N_IN + 2);
    check("t6_done", {31'b0, if12.out_valid}, 0);
    check("t6_q_empty", exp12_q.size(), 0);
    check("t6_q6_empty", exp6_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
